// File: rtl/vga_hdmi_interface3.sv
// 640x480@60 display engine: VGA timing generator plus an FWFT FIFO reader that
// expands RGB565 pixels to RGB888 and registers them alongside the sync/DE outputs.

module vga_timing (
    input  logic       clock25,
    input  logic       resetn,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync_n,
    output logic       vsync_n
);
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    logic [9:0] pixel_x_q, pixel_x_d;
    logic [9:0] pixel_y_q, pixel_y_d;

    always_comb begin
        pixel_x_d = pixel_x_q + 10'd1;
        pixel_y_d = pixel_y_q;
        if (pixel_x_q == H_LAST) begin
            pixel_x_d = 10'd0;
            pixel_y_d = (pixel_y_q == V_LAST) ? 10'd0 : pixel_y_q + 10'd1;
        end
    end

    always_ff @(posedge clock25) begin
        if (!resetn) begin
            pixel_x_q <= 10'd0;
            pixel_y_q <= 10'd0;
        end else begin
            pixel_x_q <= pixel_x_d;
            pixel_y_q <= pixel_y_d;
        end
    end

    assign pixel_x  = pixel_x_q;
    assign pixel_y  = pixel_y_q;
    assign video_on = (pixel_x_q < H_ACTIVE) && (pixel_y_q < V_ACTIVE);
    assign hsync_n  = !((pixel_x_q >= H_SYNC_START) && (pixel_x_q <= H_SYNC_END));
    assign vsync_n  = !((pixel_y_q >= V_SYNC_START) && (pixel_y_q <= V_SYNC_END));
endmodule

module vga_hdmi_interface3 (
    input  logic        clock25,
    input  logic        resetn,
    input  logic        clock50,
    input  logic        empty_fifo,
    input  logic [15:0] fifo_data_in,
    output logic        fifo_read_en,
    output logic        hsync,
    output logic        vsync,
    output logic        dataEnable,
    output logic        vgaClock,
    output logic [23:0] RGBchannel
);
    typedef enum logic [1:0] {
        ST_DELAY   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync_n;
    logic       vsync_n;

    state_t      state_q, state_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        data_enable_q, data_enable_d;
    logic [23:0] rgb_q, rgb_d;

    logic unused_clock50;
    assign unused_clock50 = clock50;

    vga_timing m0 (
        .clock25  (clock25),
        .resetn   (resetn),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .video_on (video_on),
        .hsync_n  (hsync_n),
        .vsync_n  (vsync_n)
    );

    // Handshake: empty_fifo low means fifo_data_in is valid; fifo_read_en high
    // consumes that head word at this clock edge and the FIFO presents the next one.
    assign fifo_read_en = (state_q == ST_DISPLAY) && video_on && !empty_fifo;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DELAY:   if (pixel_x == 10'd799) state_d = ST_IDLE;
            // Enter DISPLAY only at line end so the first pop lands on x = 0.
            ST_IDLE:    if ((pixel_x == 10'd799) && !empty_fifo) state_d = ST_DISPLAY;
            ST_DISPLAY: state_d = ST_DISPLAY;
            default:    state_d = ST_DELAY;
        endcase

        hsync_d       = hsync_n;
        vsync_d       = vsync_n;
        data_enable_d = video_on;
        rgb_d         = 24'h000000;
        if (fifo_read_en) begin
            rgb_d = {fifo_data_in[15:11], fifo_data_in[15:13],
                     fifo_data_in[10:5],  fifo_data_in[10:9],
                     fifo_data_in[4:0],   fifo_data_in[4:2]};
        end
    end

    always_ff @(posedge clock25) begin
        if (!resetn) begin
            state_q       <= ST_DELAY;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            data_enable_q <= 1'b0;
            rgb_q         <= 24'h000000;
        end else begin
            state_q       <= state_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            data_enable_q <= data_enable_d;
            rgb_q         <= rgb_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign dataEnable = data_enable_q;
    assign RGBchannel = rgb_q;
    assign vgaClock   = clock25;
endmodule

// File: tb/tb_vga_hdmi_interface3.sv
// Bench for vga_hdmi_interface3: FWFT FIFO model, timing/stream reference model and
// an expected-output queue compared one clock after each cycle is driven.

module tb_vga_hdmi_interface3;
  localparam int ST_DELAY   = 0;
  localparam int ST_IDLE    = 1;
  localparam int ST_DISPLAY = 2;
  localparam int N_CYCLES   = 420000 + 3 * 800;

  logic        clock25 = 1'b0;
  logic        clock50 = 1'b0;
  logic        resetn = 1'b0;
  logic        empty_fifo = 1'b1;
  logic [15:0] fifo_data_in;
  logic        fifo_read_en;
  logic        hsync;
  logic        vsync;
  logic        dataEnable;
  logic        vgaClock;
  logic [23:0] RGBchannel;

  always #20 clock25 = ~clock25;
  always #10 clock50 = ~clock50;

  vga_hdmi_interface3 dut (
    .clock25      (clock25),
    .resetn       (resetn),
    .clock50      (clock50),
    .empty_fifo   (empty_fifo),
    .fifo_data_in (fifo_data_in),
    .fifo_read_en (fifo_read_en),
    .hsync        (hsync),
    .vsync        (vsync),
    .dataEnable   (dataEnable),
    .vgaClock     (vgaClock),
    .RGBchannel   (RGBchannel)
  );

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];

  logic [15:0] known_word [5] = '{16'hF800, 16'h07E0, 16'h001F, 16'h0001, 16'h8410};
  logic [23:0] known_rgb  [5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000008, 24'h848284};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  function automatic int exp_line_pops(input int frame_no, input int y);
    if (y >= 480) return 0;
    if (frame_no == 0 && y < 2) return 0;
    if (frame_no == 0 && y == 5) return 630;
    return 640;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vsync), 32'd1);
    check({tag, "_de"}, 32'(dataEnable), 32'd0);
    check({tag, "_rgb"}, 32'(RGBchannel), 32'd0);
    check({tag, "_rd_en"}, 32'(fifo_read_en), 32'd0);
    check({tag, "_px"}, 32'(dut.m0.pixel_x), 32'd0);
    check({tag, "_py"}, 32'(dut.m0.pixel_y), 32'd0);
  endtask

  initial begin
    int tb_x, tb_y, tb_state, frame_no, pop_idx;
    int line_pops, de_cnt, hs_low, vs_low;
    logic exp_pop, popped, video, first_seen;
    logic [23:0] exp_rgb;
    logic [26:0] exp_word;
    logic [15:0] head;

    // Reset block
    head = known_word[0];
    fifo_data_in = head;
    resetn = 1'b0;
    empty_fifo = 1'b1;
    repeat (5) @(posedge clock25);
    @(negedge clock25);
    check_reset_values("reset");
    check("vga_clock", 32'(vgaClock), 32'(clock25));
    resetn = 1'b1;

    tb_x = 0; tb_y = 0; tb_state = ST_DELAY; frame_no = 0; pop_idx = 0;
    line_pops = 0; de_cnt = 0; hs_low = 0; vs_low = 0; first_seen = 1'b0;

    for (int n = 0; n < N_CYCLES; n++) begin
      // Drive this cycle's FIFO state and predict the combinational pop.
      empty_fifo = (n < 25) ||
                   (frame_no == 0 && tb_y == 5 && tb_x >= 100 && tb_x < 110);
      fifo_data_in = head;
      #1;
      if (tb_x == 0 || n < 2) begin
        check("pixel_x", 32'(dut.m0.pixel_x), 32'(tb_x));
        check("pixel_y", 32'(dut.m0.pixel_y), 32'(tb_y));
      end
      video = (tb_x < 640) && (tb_y < 480);
      exp_pop = (tb_state == ST_DISPLAY) && video && !empty_fifo;
      check("rd_en", 32'(fifo_read_en), 32'(exp_pop));
      if (exp_pop) exp_rgb = (pop_idx < 5) ? known_rgb[pop_idx] : expand(head);
      else exp_rgb = 24'h000000;
      exp_q.push_back({!(tb_x >= 656 && tb_x <= 751), !(tb_y >= 490 && tb_y <= 491),
                       video, exp_rgb});
      popped = fifo_read_en;

      @(posedge clock25);
      @(negedge clock25);
      if (exp_q.size() == 0) begin
        check("queue_underrun", 32'd0, 32'd1);
      end else begin
        exp_word = exp_q.pop_front();
        check("out", {5'd0, hsync, vsync, dataEnable, RGBchannel}, {5'd0, exp_word});
      end

      // FIFO model: head advances on each pop.
      if (popped) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          check("first_pop_x", 32'(tb_x), 32'd0);
          check("first_pop_y", 32'(tb_y), 32'd2);
        end
        pop_idx++;
        line_pops++;
        head = (pop_idx < 5) ? known_word[pop_idx] : 16'($urandom_range(0, 65535));
      end
      if (dataEnable) de_cnt++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;

      if (tb_x == 799) begin
        check("de_per_line", 32'(de_cnt), (tb_y < 480) ? 32'd640 : 32'd0);
        check("hs_per_line", 32'(hs_low), 32'd96);
        check("pops_per_line", 32'(line_pops), 32'(exp_line_pops(frame_no, tb_y)));
        de_cnt = 0; hs_low = 0; line_pops = 0;
        if (tb_y == 524) begin
          check("vs_per_frame", 32'(vs_low), 32'd1600);
          vs_low = 0;
        end
        if (tb_state == ST_DELAY) tb_state = ST_IDLE;
        else if (tb_state == ST_IDLE && !empty_fifo) tb_state = ST_DISPLAY;
      end

      if (tb_x == 799) begin
        tb_x = 0;
        if (tb_y == 524) begin
          tb_y = 0;
          frame_no++;
        end else begin
          tb_y++;
        end
      end else begin
        tb_x++;
      end
    end

    check("frame_wrapped", 32'(frame_no), 32'd1);

    // Mid-frame reset (line 3, active area) returns everything to reset values.
    empty_fifo = 1'b1;
    resetn = 1'b0;
    @(posedge clock25);
    @(negedge clock25);
    check_reset_values("midreset");
    empty_fifo = 1'b0;
    #1;
    check("midreset_rd_en_delay", 32'(fifo_read_en), 32'd0);
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock25);
      @(negedge clock25);
      check("post_reset_no_pop", 32'(fifo_read_en), 32'd0);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
